// File: rtl/sl_rx_pkg.sv
// sl_rx_pkg: shared types and constants for the SL receiver.
//   state_e  : receiver FSM states
//   err_e    : error kind latched on the way into the ERR state
//   STAT_*   : bit positions inside status_o
//   SYM_*    : synchronised {ones, zeroes} symbol codes at the strobe
package sl_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SAMPLE   = 3'd1,
      ST_WAIT_END = 3'd2,
      ST_CHECK    = 3'd3,
      ST_ERR      = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      ERR_LEN = 2'd0,
      ERR_PAR = 2'd1,
      ERR_LEV = 2'd2
   } err_e;

   localparam int STAT_LEN  = 0;
   localparam int STAT_PAR  = 1;
   localparam int STAT_LEV  = 2;
   localparam int STAT_OVF  = 3;
   localparam int STAT_BUSY = 4;
   localparam int STAT_FULL = 5;

   // {ones, zeroes}
   localparam logic [1:0] SYM_ONE  = 2'b01;
   localparam logic [1:0] SYM_ZERO = 2'b10;
   localparam logic [1:0] SYM_STOP = 2'b00;
   localparam logic [1:0] SYM_LEV  = 2'b11;

   // consecutive idle (1,1) samples that close a bit slot
   localparam int HI_RUN = 4;

endpackage

// File: rtl/sl_rx_sfifo.sv
// sl_rx_sfifo: synchronous first-word-fall-through FIFO.
//   clk, rst        : clock, async active-high reset
//   wr_en_i/wr_data_i : push request; ignored when full unless popping too
//   rd_en_i         : pop request; ignored when empty
//   rd_data_o       : head word (zero when empty)
//   count_o         : number of stored words, 0..DEPTH
module sl_rx_sfifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_wr, do_rd;

   always_comb begin
      do_rd    = rd_en_i && (cnt_q != '0);
      // a pop in the same cycle frees the slot, so a full FIFO still accepts
      do_wr    = wr_en_i && ((cnt_q != CW'(DEPTH)) || do_rd);
      wr_ptr_d = wr_ptr_q + AW'(do_wr);
      rd_ptr_d = rd_ptr_q + AW'(do_rd);
      cnt_d    = cnt_q + CW'(do_wr) - CW'(do_rd);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = (cnt_q == '0) ? '0 : mem_q[rd_ptr_q];
   assign count_o   = cnt_q;

endmodule

// File: rtl/sl_rx_fifo.sv
// sl_rx_fifo: SL (ones/zeroes two-wire) receiver with received-word FIFO.
//   sl_zeroes_i/sl_ones_i : async SL lines, idle (1,1)
//   cfg_len_i/cfg_wr_i    : word length write (IDLE only, 8..MAX_BITS) + sticky clear
//   cfg_len_o             : active word length
//   rd_data_o/rd_valid_o/rd_ready_i : FIFO head, LSB = first bit received
//   status_o              : {0,0,FULL,BUSY,OVF,LEV_ERR,PAR_ERR,LEN_ERR}
//   err_pulse_o           : one cycle per error event
// Build option: define SL_RX_PARITY_EN for one odd-parity bit per word.
import sl_rx_pkg::*;

module sl_rx_fifo #(
   parameter int OVS        = 16,
   parameter int STROB_POS  = 8,
   parameter int MAX_BITS   = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sl_zeroes_i,
   input  logic                sl_ones_i,
   input  logic [5:0]          cfg_len_i,
   input  logic                cfg_wr_i,
   output logic [5:0]          cfg_len_o,
   output logic [MAX_BITS-1:0] rd_data_o,
   output logic                rd_valid_o,
   input  logic                rd_ready_i,
   output logic [7:0]          status_o,
   output logic                err_pulse_o
);

`ifdef SL_RX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int WORD_W = MAX_BITS + PAR_BITS;
   localparam int CW     = 9;                      // holds 4*OVS-1 for OVS<=64
   localparam int FCW    = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]        sync1_q, sync2_q, prev_q;    // {ones, zeroes}
   state_e            state_q, state_d;
   err_e              err_q, err_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        hi_q, hi_d;
   logic [5:0]        bits_q, bits_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [5:0]        len_q, len_d;
   logic              len_err_q, len_err_d, lev_err_q, lev_err_d, ovf_q, ovf_d;
`ifdef SL_RX_PARITY_EN
   logic              par_err_q, par_err_d;
`endif
   logic [5:0]          exp_bits;
   logic                len_ok, par_ok, push, pop, full, ovf_evt;
   logic [MAX_BITS-1:0] push_data;
   logic [FCW-1:0]      fifo_cnt;

   assign exp_bits = len_q + 6'(PAR_BITS);
   assign len_ok   = (bits_q == exp_bits);
`ifdef SL_RX_PARITY_EN
   assign par_ok   = ^word_q;                      // odd ones count over data+parity
`else
   assign par_ok   = 1'b1;
`endif

   // 2-FF synchroniser plus one history stage for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= SYM_LEV;
         sync2_q <= SYM_LEV;
         prev_q  <= SYM_LEV;
      end else begin
         sync1_q <= {sl_ones_i, sl_zeroes_i};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         err_q     <= ERR_LEN;
         cnt_q     <= '0;
         hi_q      <= '0;
         bits_q    <= '0;
         word_q    <= '0;
         len_q     <= 6'd8;
         len_err_q <= 1'b0;
         lev_err_q <= 1'b0;
         ovf_q     <= 1'b0;
`ifdef SL_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         bits_q    <= bits_d;
         word_q    <= word_d;
         len_q     <= len_d;
         len_err_q <= len_err_d;
         lev_err_q <= lev_err_d;
         ovf_q     <= ovf_d;
`ifdef SL_RX_PARITY_EN
         par_err_q <= par_err_d;
`endif
      end
   end

   // next state
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      bits_d  = bits_q;
      word_d  = word_q;
      case (state_q)
         ST_IDLE: begin
            if (prev_q == SYM_LEV && sync2_q != SYM_LEV) begin
               state_d = ST_SAMPLE;
               cnt_d   = '0;
            end
         end
         ST_SAMPLE: begin
            if (cnt_q == CW'(STROB_POS)) begin
               cnt_d = '0;
               hi_d  = '0;
               case (sync2_q)
                  SYM_ONE, SYM_ZERO: begin
                     if (len_ok) begin
                        state_d = ST_ERR;
                        err_d   = ERR_LEN;
                     end else begin
                        word_d  = word_q | (WORD_W'(sync2_q == SYM_ONE) << bits_q);
                        bits_d  = bits_q + 6'd1;
                        state_d = ST_WAIT_END;
                     end
                  end
                  SYM_STOP: state_d = ST_CHECK;
                  default: begin
                     state_d = ST_ERR;
                     err_d   = ERR_LEV;
                  end
               endcase
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WAIT_END: begin
            cnt_d = cnt_q + CW'(1);
            hi_d  = (sync2_q == SYM_LEV) ? hi_q + 3'd1 : 3'd0;
            if (sync2_q == SYM_LEV && hi_q == 3'(HI_RUN - 1)) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CW'(4 * OVS - 1)) begin
               state_d = ST_ERR;
               err_d   = ERR_LEV;
            end
         end
         ST_CHECK: begin
            cnt_d   = '0;
            hi_d    = '0;
            bits_d  = '0;
            word_d  = '0;
            state_d = ST_WAIT_END;
            if (!len_ok) begin
               state_d = ST_ERR;
               err_d   = ERR_LEN;
            end else if (!par_ok) begin
               state_d = ST_ERR;
               err_d   = ERR_PAR;
            end
         end
         ST_ERR: begin
            cnt_d   = '0;
            hi_d    = '0;
            bits_d  = '0;
            word_d  = '0;
            state_d = ST_WAIT_END;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // outputs
   always_comb begin
      push        = (state_q == ST_CHECK) && len_ok && par_ok;
      pop         = rd_valid_o && rd_ready_i;
      ovf_evt     = push && full && !pop;
      err_pulse_o = (state_q == ST_ERR) || ovf_evt;
      // drop the parity bit (sits at index len) and anything above it
      push_data   = '0;
      for (int i = 0; i < MAX_BITS; i++) begin
         if (i < int'(len_q)) push_data[i] = word_q[i];
      end
   end

   // sticky flags and length register; a clear and a new event in the
   // same cycle leave the flag set
   always_comb begin
      len_err_d = (len_err_q && !cfg_wr_i) || (state_q == ST_ERR && err_q == ERR_LEN);
      lev_err_d = (lev_err_q && !cfg_wr_i) || (state_q == ST_ERR && err_q == ERR_LEV);
      ovf_d     = (ovf_q && !cfg_wr_i) || ovf_evt;
`ifdef SL_RX_PARITY_EN
      par_err_d = (par_err_q && !cfg_wr_i) || (state_q == ST_ERR && err_q == ERR_PAR);
`endif
      len_d = len_q;
      if (cfg_wr_i && state_q == ST_IDLE && cfg_len_i >= 6'd8 && cfg_len_i <= 6'(MAX_BITS))
         len_d = cfg_len_i;
   end

   always_comb begin
      status_o            = '0;
      status_o[STAT_LEN]  = len_err_q;
`ifdef SL_RX_PARITY_EN
      status_o[STAT_PAR]  = par_err_q;
`else
      status_o[STAT_PAR]  = 1'b0;
`endif
      status_o[STAT_LEV]  = lev_err_q;
      status_o[STAT_OVF]  = ovf_q;
      status_o[STAT_BUSY] = (state_q != ST_IDLE);
      status_o[STAT_FULL] = full;
   end

   sl_rx_sfifo #(.WIDTH(MAX_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (push),
      .wr_data_i (push_data),
      .rd_en_i   (pop),
      .rd_data_o (rd_data_o),
      .count_o   (fifo_cnt)
   );

   assign full       = (fifo_cnt == FCW'(FIFO_DEPTH));
   assign rd_valid_o = (fifo_cnt != '0);
   assign cfg_len_o  = len_q;

endmodule

// File: tb/tb_sl_rx_fifo.sv
// tb_sl_rx_fifo: scoreboard bench for sl_rx_fifo. A symbol-level model
// predicts each word's fate; good words are queued and a monitor pops and
// compares on every rd_valid_o && rd_ready_i handshake.
module tb_sl_rx_fifo;

   localparam int OVS = 16, STROB_POS = 8, MAX_BITS = 32, FIFO_DEPTH = 4;
`ifdef SL_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic                clk = 1'b0;
   logic                rst, sl_zeroes_i, sl_ones_i, cfg_wr_i, rd_ready_i;
   logic [5:0]          cfg_len_i, cfg_len_o;
   logic [MAX_BITS-1:0] rd_data_o;
   logic                rd_valid_o, err_pulse_o;
   logic [7:0]          status_o;

   sl_rx_fifo #(.OVS(OVS), .STROB_POS(STROB_POS), .MAX_BITS(MAX_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .sl_zeroes_i(sl_zeroes_i), .sl_ones_i(sl_ones_i),
      .cfg_len_i(cfg_len_i), .cfg_wr_i(cfg_wr_i), .cfg_len_o(cfg_len_o),
      .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
      .status_o(status_o), .err_pulse_o(err_pulse_o)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   logic [MAX_BITS-1:0] exp_q[$];
   bit  m_bits[$];
   int  m_len = 8;
   bit  m_len_err, m_par_err, m_lev_err, m_ovf;
   int  m_pulses = 0, seen_pulses = 0;
   bit  rdy_rand = 1'b0, rdy_force = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ready driver
   initial begin
      rd_ready_i = 1'b0;
      forever begin
         @(posedge clk); #1;
         rd_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
      end
   end

   // monitor: compare every accepted word against the scoreboard
   always @(negedge clk) begin
      if (err_pulse_o) seen_pulses++;
      if (!rst && rd_valid_o && rd_ready_i) begin
         if (exp_q.size() == 0) chk("unexpected_word", 64'(rd_data_o), 64'hdead);
         else chk("rd_data", 64'(rd_data_o), 64'(exp_q.pop_front()));
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sym(input logic ones, input logic zeroes, input int lo, input int hi);
      sl_ones_i = ones; sl_zeroes_i = zeroes;
      wait_cyc(lo);
      sl_ones_i = 1'b1; sl_zeroes_i = 1'b1;
      wait_cyc(hi);
   endtask

   task automatic m_err(input int kind);
      m_pulses++;
      case (kind)
         0: m_len_err = 1'b1;
         1: m_par_err = 1'b1;
         default: m_lev_err = 1'b1;
      endcase
   endtask

   task automatic send_bit(input bit b);
      if (m_bits.size() == m_len + PAR) begin
         m_err(0);
         m_bits.delete();
      end else m_bits.push_back(b);
      sym(~b, b, 14, 10);
   endtask

   task automatic send_stop();
      logic [MAX_BITS-1:0] w;
      int ones;
      if (m_bits.size() != m_len + PAR) m_err(0);
      else begin
         ones = 0;
         foreach (m_bits[i]) ones += int'(m_bits[i]);
         if (PAR == 1 && ones % 2 == 0) m_err(1);
         else begin
            w = '0;
            for (int i = 0; i < m_len; i++) w[i] = m_bits[i];
            if (exp_q.size() >= FIFO_DEPTH) begin m_ovf = 1'b1; m_pulses++; end
            else exp_q.push_back(w);
         end
      end
      m_bits.delete();
      sym(1'b0, 1'b0, 14, 10);
   endtask

   task automatic send_lev();
      m_err(2);
      m_bits.delete();
      sym(1'b0, 1'b1, 4, 20);
   endtask

   task automatic send_word(input logic [63:0] b, input int n, input bit stop);
      for (int i = 0; i < n; i++) send_bit(b[i]);
      if (stop) send_stop();
      wait_cyc(4);
   endtask

   // data word with correct (odd) parity appended when enabled
   function automatic logic [63:0] mk(input logic [63:0] d, input int len);
      logic [63:0] m;
      m = d & ((64'd1 << len) - 64'd1);
      if (PAR == 1) m = m | (64'(~^m) << len);
      return m;
   endfunction

   task automatic cfg_write(input logic [5:0] len);
      cfg_len_i = len; cfg_wr_i = 1'b1;
      wait_cyc(1);
      cfg_wr_i = 1'b0;
      m_len_err = 0; m_par_err = 0; m_lev_err = 0; m_ovf = 0;
      if (len >= 6'd8 && len <= 6'(MAX_BITS)) m_len = int'(len);
   endtask

   task automatic chk_stat(input string name);
      chk(name, 64'(status_o[4:0]), 64'({1'b0, m_ovf, m_lev_err, m_par_err, m_len_err}));
      chk({name, "_pulses"}, 64'(seen_pulses), 64'(m_pulses));
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin wait_cyc(1); n++; end
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, "_valid"}, 64'(rd_valid_o), 64'd0);
      chk({name, "_data"}, 64'(rd_data_o), 64'd0);
      chk({name, "_status"}, 64'(status_o), 64'd0);
      chk({name, "_pulse"}, 64'(err_pulse_o), 64'd0);
      chk({name, "_len"}, 64'(cfg_len_o), 64'd8);
   endtask

   initial begin
      logic [63:0] d;
      int kind, n;
      rst = 1'b1; sl_ones_i = 1'b1; sl_zeroes_i = 1'b1; cfg_wr_i = 1'b0; cfg_len_i = '0;
      wait_cyc(3);
      chk_reset_vals("reset");
      rst = 1'b0;
      wait_cyc(3);

      // 0xA5, held in the FIFO
      cfg_write(6'd8);
      send_word(mk(64'hA5, 8), 8 + PAR, 1'b1);
      chk("a5_valid", 64'(rd_valid_o), 64'd1);
      chk("a5_head", 64'(rd_data_o), 64'hA5);
      chk("a5_status", 64'(status_o), 64'h00);
      rdy_force = 1'b1;
      drain();

      // short word
      send_word(mk(64'h5A, 8), 7 + PAR, 1'b1);
      chk_stat("short");
      chk("short_empty", 64'(rd_valid_o), 64'd0);

`ifdef SL_RX_PARITY_EN
      cfg_write(6'd8);
      send_word(64'h101, 9, 1'b1);
      chk_stat("parity");
      chk("parity_status", 64'(status_o), 64'h02);
      cfg_write(6'd8);
      chk("parity_clear", 64'(status_o), 64'h00);
`endif

      // level error mid-word
      cfg_write(6'd8);
      send_word(64'h3, 3, 1'b0);
      send_lev();
      wait_cyc(4);
      chk_stat("lev");
      chk("lev_bit", 64'(status_o[2]), 64'd1);

      // illegal lengths leave cfg_len unchanged
      cfg_write(6'd12);
      chk("len12", 64'(cfg_len_o), 64'd12);
      cfg_write(6'd40);
      chk("len40", 64'(cfg_len_o), 64'd12);
      cfg_write(6'd5);
      chk("len5", 64'(cfg_len_o), 64'd12);
      chk("len_clear", 64'(status_o), 64'h00);

      // overflow: 5 words into a 4-deep FIFO with no consumer
      cfg_write(6'd8);
      rdy_force = 1'b0;
      wait_cyc(2);
      for (int i = 0; i < 5; i++) send_word(mk(64'(8'h11 * (i + 1)), 8), 8 + PAR, 1'b1);
      chk_stat("ovf");
      chk("ovf_full", 64'(status_o[5]), 64'd1);
      chk("ovf_head", 64'(rd_data_o), 64'h11);
      rdy_force = 1'b1;
      drain();
      wait_cyc(2);
      chk("ovf_notfull", 64'(status_o[5]), 64'd0);

      // reset between bits of a word
      cfg_write(6'd10);
      send_word(64'h5, 3, 1'b0);
      rst = 1'b1;
      wait_cyc(2);
      chk_reset_vals("midrst");
      exp_q.delete(); m_bits.delete(); m_len = 8;
      m_len_err = 0; m_par_err = 0; m_lev_err = 0; m_ovf = 0;
      rst = 1'b0;
      wait_cyc(3);
      send_word(mk(64'h3C, 8), 8 + PAR, 1'b1);
      drain();
      chk_stat("post_rst");

      // randomized words, lengths and consumer
      rdy_rand = 1'b1;
      for (int it = 0; it < 20; it++) begin
         if (it % 5 == 0) cfg_write(6'($urandom_range(4, 40)));
         d    = {$urandom, $urandom};
         kind = $urandom_range(0, 9);
         n    = m_len + PAR;
         if (kind == 0) n = n - 1;
         if (kind == 1) n = n + 1;
         d = mk(d, m_len) | (64'($urandom_range(0, 1)) << (m_len + PAR));
         if (kind == 2 && PAR == 1) d = d ^ (64'd1 << m_len);
         if (kind == 3) begin
            send_word(d, $urandom_range(0, m_len - 1), 1'b0);
            send_lev();
            wait_cyc(4);
         end else send_word(d, n, 1'b1);
         chk_stat("rand");
      end
      drain();
      chk_stat("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sl_rx_fifo.md
SL_RX_FIFO -- requirements
Module: sl_rx_fifo

Interface
REQ-001 Parameter OVS, default 16: clk cycles per SL bit slot; range 8..64.
REQ-002 Parameter STROB_POS, default 8: sample cycle counted from bit-start detect; 2 <= STROB_POS < OVS.
REQ-003 Parameter MAX_BITS, default 32: widest data word; range 8..32.
REQ-004 Parameter FIFO_DEPTH, default 4: received-word buffer depth; power of 2, range 2..16.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 sl_zeroes_i  in  1  SL zeroes line, asynchronous to clk.
REQ-008 sl_ones_i  in  1  SL ones line, asynchronous to clk.
REQ-009 cfg_len_i  in  6  configured data bits per word, excluding parity.
REQ-010 cfg_wr_i  in  1  one-cycle strobe: write cfg_len_i and clear sticky flags.
REQ-011 cfg_len_o  out  6  active word length.
REQ-012 rd_data_o  out  MAX_BITS  FIFO head word, LSB = first bit received, unused MSBs zero.
REQ-013 rd_valid_o  out  1  FIFO non-empty.
REQ-014 rd_ready_i  in  1  consumer accepts head word when rd_valid_o && rd_ready_i.
REQ-015 status_o  out  8  [0] LEN_ERR, [1] PAR_ERR, [2] LEV_ERR, [3] OVF, [4] BUSY, [5] FULL, [7:6] zero.
REQ-016 err_pulse_o  out  1  one-cycle pulse on any error event.

Function
REQ-017 Both SL inputs pass through a 2-FF synchroniser; all decoding uses the synchronised values.
REQ-018 Symbol encoding at strobe: (ones,zeroes)=(0,1) is data 1; (1,0) is data 0; (0,0) is stop; (1,1) is a level error.
REQ-019 FSM states: IDLE, SAMPLE, WAIT_END, CHECK, ERR; encoding is implementation-defined.
REQ-020 IDLE->SAMPLE when the previous synchronised sample is (1,1) and the current one has either line low; the cycle counter loads 0.
REQ-021 SAMPLE increments the counter each cycle; at counter == STROB_POS it decodes the symbol per REQ-018.
REQ-022 A data symbol shifts into the word register, increments the bit counter and moves to WAIT_END.
REQ-023 A data symbol arriving when the bit counter already equals the expected count is a length error.
REQ-024 A stop symbol moves to CHECK; a (1,1) symbol moves to ERR as LEV_ERR.
REQ-025 WAIT_END->IDLE after 4 consecutive (1,1) samples.
REQ-026 WAIT_END->ERR as LEV_ERR if it has not exited after 4*OVS cycles.
REQ-027 CHECK: a bit count different from the expected count is LEN_ERR; otherwise the word is pushed to the FIFO.
REQ-028 rd_valid_o rises on the cycle after CHECK; the accumulators clear and the FSM enters WAIT_END.
REQ-029 A push into a full FIFO drops the word and sets OVF; the FIFO contents are unchanged.
REQ-030 A simultaneous push and pop on a full FIFO succeeds with no overflow.
REQ-031 ERR lasts one cycle: sets the sticky flag, pulses err_pulse_o, clears the accumulators and moves to WAIT_END.
REQ-032 Status flags [2:0] and OVF are sticky until cfg_wr_i.
REQ-033 BUSY = state != IDLE. FULL = FIFO count == FIFO_DEPTH.
REQ-034 cfg_wr_i is applied only in IDLE with 8 <= cfg_len_i <= MAX_BITS.
REQ-035 Otherwise the length is unchanged, and pending flags are still cleared.

Reset
REQ-036 rst asserted: FSM=IDLE, counters 0, FIFO empty, rd_valid_o=0, rd_data_o=0, status_o=0, err_pulse_o=0, cfg_len_o=8, synchronisers=(1,1).
REQ-037 rst asserted mid-word discards the partial word.
REQ-038 After rst release, the first word is detected only after a (1,1)->low transition.

Configuration
REQ-039 Macro SL_RX_PARITY_EN defined: each word carries one extra parity bit before the stop symbol, so the expected count is cfg_len+1.
REQ-040 With SL_RX_PARITY_EN: the ones count over data+parity is odd, else PAR_ERR is raised and the word is not pushed.
REQ-041 With SL_RX_PARITY_EN: the parity bit is stripped from rd_data_o.
REQ-042 SL_RX_PARITY_EN undefined: the expected count is cfg_len, status_o[1] is tied 0, and no parity logic is built.

Structure
REQ-043 Package sl_rx_pkg holds the FSM state type, the status bit index constants and the symbol encoding constants.
REQ-044 FIFO is sub-module sl_rx_sfifo (WIDTH, DEPTH): synchronous, first-word-fall-through, with count output.

Verification
REQ-045 cfg_len=8, default OVS, send 0xA5 (parity 1 if enabled) + stop -> rd_data_o=0x000000A5, rd_valid_o=1, status_o=0x00.
REQ-046 cfg_len=8, send 7 bits + stop -> LEN_ERR set, err_pulse_o one cycle, FIFO stays empty.
REQ-047 SL_RX_PARITY_EN, 0x01 with parity 1 -> PAR_ERR, no push; then cfg_wr_i -> status_o=0x00.
REQ-048 FIFO_DEPTH=4, rd_ready_i=0, send 5 words -> FULL=1, OVF=1, first 4 words read back in order.
REQ-049 Lines go to (1,1) before strobe -> LEV_ERR set.
REQ-050 rst pulsed mid-word -> all outputs return to REQ-036 values and the next word decodes correctly.
REQ-051 cfg_wr_i with cfg_len_i=40 or 5 -> cfg_len_o unchanged.
